// File: rtl/serial_add_pkg.sv
// serial_add_pkg -- shared definitions for the bit-serial adder/subtractor.
//   DEFAULT_WIDTH : default operand/result width in bits
//   state_t       : controller FSM state (IDLE / RUN / DONE)
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if -- request/result bundle of serial_add_ctrl.
//   start        : request to begin one operation
//   op_a, op_b   : operands, captured when start is accepted
//   sub          : 1 = A minus B (honoured only when SERIAL_ADD_SUB_EN is defined)
//   busy         : operation in progress
//   done         : one-cycle pulse, sum/cout/ovf carry a new result
//   sum/cout/ovf : registered result, held until the next result
//
// Handshake: start is the valid and !busy is the ready. A request is accepted
// on a rising edge where start=1 and busy=0 (idle, or the done cycle for
// back-to-back work). start while busy is dropped, not queued. Operands and
// sub only need to be stable on the accepting edge.
interface serial_add_ctrl_if #(
  parameter int WIDTH = serial_add_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, op_a, op_b, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, op_a, op_b, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_fa_bit.sv
// serial_fa_bit -- 1-bit full adder made of two half adders and an OR.
//   a, b : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module serial_fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s1;
  logic c1;
  logic c2;

  // first half adder: a + b
  assign s1 = a ^ b;
  assign c1 = a & b;
  // second half adder: partial sum + carry in
  assign s  = s1 ^ ci;
  assign c2 = s1 & ci;
  // the two half-adder carries can never both be 1
  assign co = c1 | c2;
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl -- bit-serial adder/subtractor, LSB first, one bit per clock,
// sequenced around a single shared full-adder cell.
//   clk       : clock, all state changes on the rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : serial_add_ctrl_if.slave (start/op_a/op_b/sub in,
//               busy/done/sum/cout/ovf out)
//   dbg_state : current FSM state
// Build option: define SERIAL_ADD_SUB_EN to let 'sub' select A-B; without it
// 'sub' is ignored and every operation is A+B.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_add_ctrl_if.slave   bus,
  output state_t             dbg_state
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sub_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_o;
  logic             done_o;

  logic             sub_in;
  logic             accept;
  logic             fa_b;
  logic             fa_s;
  logic             fa_co;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_in = bus.sub;
`else
  logic unused_sub;
  assign unused_sub = bus.sub;
  assign sub_in     = 1'b0;
`endif

  // accepted in IDLE or DONE; RUN ignores start
  assign accept = bus.start && (state_q != RUN);

  // subtraction = A + ~B + 1; the +1 is the carry preloaded on accept
  assign fa_b = b_sh[0] ^ sub_q;

  serial_fa_bit u_fa (
    .a  (a_sh[0]),
    .b  (fa_b),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs decoded from registered state only
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      RUN:     busy_o = 1'b1;
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  // datapath: operand shifters, result shifter, carry, bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      r_sh    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_sh    <= bus.op_a;
      b_sh    <= bus.op_b;
      sub_q   <= sub_in;
      carry_q <= sub_in;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      r_sh    <= {fa_s, r_sh[WIDTH-1:1]};
      carry_q <= fa_co;
      cnt_q   <= cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        // last bit: carry_q is the carry into the MSB, fa_co the carry out
        sum_q  <= {fa_s, r_sh[WIDTH-1:1]};
        cout_q <= fa_co;
        ovf_q  <= fa_co ^ carry_q;
      end
    end
  end

  assign bus.busy  = busy_o;
  assign bus.done  = done_o;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin one addition.
REQ-005 SHALL have port op_a  input  WIDTH  operand A, sampled on accepted start.
REQ-006 SHALL have port op_b  input  WIDTH  operand B, sampled on accepted start.
REQ-007 SHALL have port sub  input  1  1 = A minus B, sampled on accepted start (see Configuration).
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse when result is valid.
REQ-010 SHALL have port sum  output  WIDTH  registered result.
REQ-011 SHALL have port cout  output  1  carry out of MSB (for subtract: 1 = no borrow).
REQ-012 SHALL have port ovf  output  1  signed two's-complement overflow.

Function
REQ-013 SHALL sequence one shared 1-bit full-adder cell, LSB first, one bit per clock.
REQ-014 FSM states SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-015 IDLE: start=1 SHALL capture op_a/op_b/sub into shift registers, clear bit counter, load carry register with carry-in (0 add, 1 subtract), go to RUN.
REQ-016 RUN: each cycle SHALL add bit0 of A-shift, bit0 of B-shift (inverted when subtracting) and carry reg; shift sum bit into result shift reg MSB; update carry; increment counter.
REQ-017 RUN SHALL last exactly WIDTH cycles; on counter = WIDTH-1 go to DONE and load sum, cout, ovf registers.
REQ-018 ovf SHALL equal carry into MSB XOR carry out of MSB.
REQ-019 DONE SHALL last one cycle with done=1, busy=0; start=1 in DONE SHALL be accepted as in IDLE (back-to-back), otherwise go to IDLE.
REQ-020 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-021 Latency: start sampled at edge N -> done high during cycle following edge N+WIDTH; throughput one op per WIDTH+1 cycles.
REQ-022 start in RUN SHALL be ignored (no queueing); operand changes after acceptance SHALL not affect the result.
REQ-023 sum/cout/ovf SHALL hold the last result until the next DONE load.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter/shift/carry regs 0, including mid-RUN (operation discarded).
REQ-025 After rst_n deassertion the block SHALL accept start on the first rising edge.

Configuration
REQ-026 Macro SERIAL_ADD_SUB_EN defined: sub SHALL select subtraction (B inverted, carry-in 1).
REQ-027 Macro SERIAL_ADD_SUB_EN undefined: sub port SHALL remain but be ignored; every operation is A+B with carry-in 0.

Structure
REQ-028 Package serial_add_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and default WIDTH constant.
REQ-029 The 1-bit adder SHALL be a sub-module serial_fa_bit built from two half adders plus OR for carry; exactly one instance.
REQ-030 Counter width SHALL be $clog2(WIDTH) bits; no combinational path from inputs to outputs.

Verification (WIDTH=8, SERIAL_ADD_SUB_EN defined unless noted)
REQ-031 start, A=0x0F, B=0x01, sub=0 -> busy 8 cycles, done pulse 1 cycle, sum=0x10, cout=0, ovf=0.
REQ-032 A=0xFF, B=0x01 add -> sum=0x00, cout=1, ovf=0; A=0x7F, B=0x01 -> sum=0x80, cout=0, ovf=1.
REQ-033 A=0x05, B=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0; same with macro undefined -> sum=0x0C.
REQ-034 Second start pulsed in RUN with A=0xAA -> ignored; first result unchanged; start held through DONE -> second op begins immediately, done pulses 9 cycles apart.
REQ-035 rst_n low at RUN cycle 4 -> busy/done/sum/cout/ovf 0 asynchronously; new start after release completes correctly.
